// File: rtl/stdp_pkg.sv
// Shared types and arithmetic helpers for the STDP learning engine.
// Optional LTD support is selected in the engine by the STDP_LTD_EN macro.
package stdp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LTP_SCAN,
    LTD_SCAN
  } stdp_state_e;

  // Exponential decay approximated by one right shift per cycle of separation.
  function automatic int stdp_delta(input int amp, input int dt);
    if (dt < 1 || dt > 31) return 0;
    return amp >>> (dt - 1);
  endfunction

  function automatic int sat_add(input int w, input int delta, input logic sign,
                                 input int w_max);
    int r;
    r = sign ? (w - delta) : (w + delta);
    if (r < 0) r = 0;
    else if (r > w_max) r = w_max;
    return r;
  endfunction

endpackage

// File: rtl/stdp_nearest_age.sv
// Lowest-set-bit encoder over a spike history: reports whether any spike is
// present and the age (1..WIN) of the most recent one.
module stdp_nearest_age #(
  parameter int WIN  = 8,
  parameter int DT_W = $clog2(WIN + 1)
) (
  input  logic [WIN-1:0]  hist,
  output logic            hit,
  output logic [DT_W-1:0] dt
);

  // Scanning downward lets the lowest set bit overwrite any older spike.
  always_comb begin
    hit = |hist;
    dt  = '0;
    for (int j = WIN - 1; j >= 0; j--) begin
      if (hist[j]) dt = DT_W'(j + 1);
    end
  end

endmodule

// File: rtl/stdp_learning_engine.sv
// Nearest-neighbour STDP engine with N_PRE saturating weights and a sequential
// LTP scan; define STDP_LTD_EN to add post-age tracking and the LTD scan.
module stdp_learning_engine
  import stdp_pkg::*;
#(
  parameter int N_PRE   = 16,
  parameter int WIN     = 8,
  parameter int W_W     = 4,
  parameter int W_INIT  = 8,
  parameter int A_PLUS  = 4,
  parameter int A_MINUS = 4,
  localparam int IDX_W  = $clog2(N_PRE)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_PRE-1:0] pre_spike,
  input  logic             post_spike,
  input  logic             learn_en,
  input  logic [IDX_W-1:0] rd_sel,
  output logic [W_W-1:0]   rd_weight,
  output logic             busy,
  output logic             upd_valid,
  output logic [IDX_W-1:0] upd_idx,
  output logic [W_W-1:0]   upd_weight
);

  localparam int DT_W  = $clog2(WIN + 1);
  localparam int W_MAX = (1 << W_W) - 1;

  stdp_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIN-1:0]   pre_hist_q [N_PRE];
  logic [WIN-1:0]   pre_hist_d [N_PRE];
  logic [WIN-1:0]   snap_q [N_PRE];
  logic [WIN-1:0]   snap_d [N_PRE];
  logic [W_W-1:0]   weight_q [N_PRE];
  logic [W_W-1:0]   weight_d [N_PRE];

  logic             post_capture;
  logic             ltp_hit;
  logic [DT_W-1:0]  ltp_dt;
  int               ltp_delta;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [W_W-1:0]   wr_weight;

  stdp_nearest_age #(
    .WIN  (WIN),
    .DT_W (DT_W)
  ) u_nearest_age (
    .hist (snap_q[idx_q]),
    .hit  (ltp_hit),
    .dt   (ltp_dt)
  );

  assign post_capture = post_spike && learn_en && (state_q != LTP_SCAN);

  always_comb begin
    ltp_delta = 0;
    if (ltp_hit) ltp_delta = stdp_delta(A_PLUS, int'(ltp_dt));
  end

`ifdef STDP_LTD_EN
  logic [DT_W-1:0]  post_age_q, post_age_d;
  logic [N_PRE-1:0] pend_q, pend_d;
  logic [DT_W-1:0]  dt_ltd_q [N_PRE];
  logic [DT_W-1:0]  dt_ltd_d [N_PRE];
  logic             ltd_found;
  logic [IDX_W-1:0] ltd_idx;
  int               ltd_delta;

  // Age as seen after this edge, so a same-cycle pre/post pair yields 0.
  always_comb begin
    post_age_d = post_age_q;
    if (post_spike) post_age_d = '0;
    else if (post_age_q != DT_W'(WIN)) post_age_d = post_age_q + 1'b1;
  end

  always_comb begin
    ltd_found = 1'b0;
    ltd_idx   = '0;
    for (int i = 0; i < N_PRE; i++) begin
      if (!ltd_found && pend_q[i]) begin
        ltd_found = 1'b1;
        ltd_idx   = IDX_W'(i);
      end
    end
    ltd_delta = stdp_delta(A_MINUS, int'(dt_ltd_q[ltd_idx]));
  end
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    weight_d  = weight_q;
    wr_en     = 1'b0;
    wr_idx    = '0;
    wr_weight = '0;
    for (int i = 0; i < N_PRE; i++) begin
      pre_hist_d[i] = {pre_hist_q[i][WIN-2:0], pre_spike[i]};
    end
`ifdef STDP_LTD_EN
    pend_d   = pend_q;
    dt_ltd_d = dt_ltd_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef STDP_LTD_EN
        if (|pend_q) state_d = LTD_SCAN;
`endif
      end
      LTP_SCAN: begin
        if (ltp_delta != 0) begin
          wr_en     = 1'b1;
          wr_idx    = idx_q;
          wr_weight = W_W'(sat_add(int'(weight_q[idx_q]), ltp_delta, 1'b0, W_MAX));
        end
        if (idx_q == IDX_W'(N_PRE - 1)) begin
          idx_d = '0;
`ifdef STDP_LTD_EN
          state_d = LTD_SCAN;
`else
          state_d = IDLE;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
`ifdef STDP_LTD_EN
      LTD_SCAN: begin
        if (!post_capture && ltd_found) begin
          pend_d[ltd_idx] = 1'b0;
          if (ltd_delta != 0) begin
            wr_en     = 1'b1;
            wr_idx    = ltd_idx;
            wr_weight = W_W'(sat_add(int'(weight_q[ltd_idx]), ltd_delta, 1'b1, W_MAX));
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (wr_en) weight_d[wr_idx] = wr_weight;

    // A post capture pre-empts an LTD scan; pending channels are kept.
    if (post_capture) begin
      state_d = LTP_SCAN;
      idx_d   = '0;
      snap_d  = pre_hist_q;
    end

`ifdef STDP_LTD_EN
    for (int i = 0; i < N_PRE; i++) begin
      if (pre_spike[i] && learn_en && post_age_d != '0 && post_age_d < DT_W'(WIN)) begin
        pend_d[i]   = 1'b1;
        dt_ltd_d[i] = post_age_d;
      end
    end
    if (state_d == LTD_SCAN && pend_d == '0) state_d = IDLE;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int i = 0; i < N_PRE; i++) begin
        pre_hist_q[i] <= '0;
        snap_q[i]     <= '0;
        weight_q[i]   <= W_W'(W_INIT);
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pre_hist_q <= pre_hist_d;
      snap_q     <= snap_d;
      weight_q   <= weight_d;
    end
  end

`ifdef STDP_LTD_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      post_age_q <= '0;
      pend_q     <= '0;
      for (int i = 0; i < N_PRE; i++) dt_ltd_q[i] <= '0;
    end else begin
      post_age_q <= post_age_d;
      pend_q     <= pend_d;
      dt_ltd_q   <= dt_ltd_d;
    end
  end
`endif

  assign rd_weight  = weight_q[rd_sel];
  assign busy       = (state_q == LTP_SCAN);
  assign upd_valid  = wr_en;
  assign upd_idx    = wr_idx;
  assign upd_weight = wr_weight;

endmodule

// File: tb/tb_stdp_learning_engine.sv
// Directed bench for stdp_learning_engine; LTD expectations follow STDP_LTD_EN.
module tb_stdp_learning_engine;

  logic        clock;
  logic        reset_n;
  logic [15:0] pre_spike;
  logic        post_spike;
  logic        learn_en;
  logic [3:0]  rd_sel;
  logic [3:0]  rd_weight;
  logic        busy;
  logic        upd_valid;
  logic [3:0]  upd_idx;
  logic [3:0]  upd_weight;

  int check_count;
  int pass_count;
  int busy_cnt;
  int write_count;
  int wr_idx_log [8];
  int wr_w_log [8];

  stdp_learning_engine dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .pre_spike  (pre_spike),
    .post_spike (post_spike),
    .learn_en   (learn_en),
    .rd_sel     (rd_sel),
    .rd_weight  (rd_weight),
    .busy       (busy),
    .upd_valid  (upd_valid),
    .upd_idx    (upd_idx),
    .upd_weight (upd_weight)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record scan activity and every weight write, sampled mid-cycle.
  always @(negedge clock) begin
    if (busy) busy_cnt++;
    if (upd_valid) begin
      if (write_count < 8) begin
        wr_idx_log[write_count] = int'(upd_idx);
        wr_w_log[write_count]   = int'(upd_weight);
      end
      write_count++;
    end
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, want %0d", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic [15:0] pre, input logic post);
    pre_spike  = pre;
    post_spike = post;
    @(negedge clock);
    pre_spike  = '0;
    post_spike = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clearLog();
    busy_cnt    = 0;
    write_count = 0;
  endtask

  task automatic checkWeight(input string tag, input int ch, input int expected);
    rd_sel = 4'(ch);
    #1;
    checkOutput(tag, int'(rd_weight), expected);
  endtask

  initial begin
    int sat_exp [5];
    int ltd_exp [5];
    sat_exp = '{12, 15, 15, 15, 15};
    ltd_exp = '{6, 4, 2, 0, 0};
    check_count = 0;
    pass_count  = 0;
    reset_n     = 1'b0;
    pre_spike   = '0;
    post_spike  = 1'b0;
    learn_en    = 1'b1;
    rd_sel      = '0;
    clearLog();

    idle(2);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_upd_valid", int'(upd_valid), 0);
    checkOutput("rst_upd_idx", int'(upd_idx), 0);
    checkOutput("rst_upd_weight", int'(upd_weight), 0);
    checkWeight("rst_w0", 0, 8);
    checkWeight("rst_w15", 15, 8);

    reset_n = 1'b1;
    idle(12);

    $display("[TB] potentiation dt=1 on channel 1");
    clearLog();
    applyStimulus(16'h0002, 1'b0);
    applyStimulus(16'h0000, 1'b1);
    checkOutput("ltp_busy_start", int'(busy), 1);
    idle(30);
    checkOutput("ltp_busy_cycles", busy_cnt, 16);
    checkOutput("ltp_write_count", write_count, 1);
    checkOutput("ltp_write_idx", wr_idx_log[0], 1);
    checkOutput("ltp_write_w", wr_w_log[0], 12);
    checkWeight("ltp_w1", 1, 12);

    $display("[TB] window decay on channel 5");
    clearLog();
    applyStimulus(16'h0020, 1'b0);
    idle(2);
    applyStimulus(16'h0000, 1'b1);
    idle(30);
    checkOutput("dt3_write_count", write_count, 1);
    checkOutput("dt3_write_w", wr_w_log[0], 9);
    checkWeight("dt3_w5", 5, 9);
    clearLog();
    applyStimulus(16'h0020, 1'b0);
    idle(8);
    applyStimulus(16'h0000, 1'b1);
    idle(30);
    checkOutput("dt9_busy_cycles", busy_cnt, 16);
    checkOutput("dt9_write_count", write_count, 0);
    checkWeight("dt9_w5", 5, 9);

    $display("[TB] saturation on channel 2");
    for (int k = 0; k < 5; k++) begin
      clearLog();
      applyStimulus(16'h0004, 1'b0);
      applyStimulus(16'h0000, 1'b1);
      idle(30);
      checkOutput($sformatf("sat%0d_write_count", k), write_count, 1);
      checkWeight($sformatf("sat%0d_w2", k), 2, sat_exp[k]);
    end

    $display("[TB] learn_en low blocks capture");
    clearLog();
    learn_en = 1'b0;
    applyStimulus(16'h0200, 1'b0);
    applyStimulus(16'h0000, 1'b1);
    idle(30);
    learn_en = 1'b1;
    checkOutput("nolearn_busy_cycles", busy_cnt, 0);
    checkOutput("nolearn_write_count", write_count, 0);

    $display("[TB] same-cycle pre/post on channel 4");
    clearLog();
    applyStimulus(16'h0010, 1'b1);
    idle(30);
    checkOutput("coll_write_count", write_count, 0);
    checkWeight("coll_w4", 4, 8);

    $display("[TB] depression on channel 3");
    for (int k = 0; k < 5; k++) begin
      clearLog();
      applyStimulus(16'h0000, 1'b1);
      idle(1);
      applyStimulus(16'h0008, 1'b0);
      idle(30);
`ifdef STDP_LTD_EN
      checkOutput($sformatf("ltd%0d_write_count", k), write_count, 1);
      checkWeight($sformatf("ltd%0d_w3", k), 3, ltd_exp[k]);
`else
      checkOutput($sformatf("ltd%0d_write_count", k), write_count, 0);
      checkWeight($sformatf("ltd%0d_w3", k), 3, 8);
`endif
    end

    $display("[TB] post arriving during LTD scan");
    clearLog();
    applyStimulus(16'h0000, 1'b1);
    applyStimulus(16'h00C0, 1'b0);
    idle(13);
    applyStimulus(16'h0100, 1'b0);
    idle(1);
    applyStimulus(16'h0000, 1'b1);
    idle(40);
    checkOutput("susp_first_idx", wr_idx_log[0], 8);
    checkOutput("susp_first_w", wr_w_log[0], 10);
    checkWeight("susp_w8", 8, 10);
`ifdef STDP_LTD_EN
    checkOutput("susp_write_count", write_count, 3);
    checkOutput("susp_second_idx", wr_idx_log[1], 6);
    checkOutput("susp_third_idx", wr_idx_log[2], 7);
    checkWeight("susp_w6", 6, 4);
    checkWeight("susp_w7", 7, 4);
`else
    checkOutput("susp_write_count", write_count, 1);
    checkWeight("susp_w6", 6, 8);
`endif

    $display("[TB] reset in the middle of a scan");
    clearLog();
    applyStimulus(16'h0002, 1'b0);
    applyStimulus(16'h0000, 1'b1);
    idle(7);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_upd_valid", int'(upd_valid), 0);
    checkWeight("midrst_w1", 1, 8);
    checkWeight("midrst_w2", 2, 8);
    idle(2);
    reset_n = 1'b1;
    idle(12);
    clearLog();
    applyStimulus(16'h0002, 1'b0);
    applyStimulus(16'h0000, 1'b1);
    idle(30);
    checkOutput("post_rst_busy_cycles", busy_cnt, 16);
    checkOutput("post_rst_write_count", write_count, 1);
    checkOutput("post_rst_write_idx", wr_idx_log[0], 1);
    checkWeight("post_rst_w1", 1, 12);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
